// File: rtl/bus_wait_memory.sv
// Byte-wide synchronous memory with a configurable number of bus wait states.
// Optional sticky read trap at TRAP_ADDR, enabled by defining BUS_WAIT_MEMORY_TRAP_EN.
module bus_wait_memory #(
   parameter int          ADDR_W      = 21,
   parameter int          DEPTH_LOG2  = 16,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [15:0] TRAP_ADDR   = 16'hBEEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        dIn,
   output logic [7:0]        dOut,
   output logic              rdy,
   output logic              trap,
   output logic [15:0]       access_count
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              opRe_q, opRe_d;
   logic              opWe_q, opWe_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              rdy_q, rdy_d;
   logic [7:0]        dOut_q;
   logic [15:0]       count_q;

   logic              accDo;
   logic              accRe;
   logic              accWe;
   logic [ADDR_W-1:0] accAddr;
   logic [7:0]        accData;
   logic [DEPTH_LOG2-1:0] accIdx;
   logic              unusedAddrBits;

   logic [7:0] mem_q [2**DEPTH_LOG2];

   // accDo marks the edge on which an access really completes, either directly
   // from the bus (no wait states) or from the copy latched on entry to WAIT.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opRe_d  = opRe_q;
      opWe_d  = opWe_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdy_d   = rdy_q;
      accDo   = 1'b0;
      accRe   = 1'b0;
      accWe   = 1'b0;
      accAddr = '0;
      accData = '0;
      unique case (state_q)
         IDLE: begin
            if (re || we) begin
               if (WAIT_CYCLES == 0) begin
                  accDo   = 1'b1;
                  accRe   = re;
                  accWe   = we;
                  accAddr = addr;
                  accData = dIn;
               end else begin
                  opRe_d  = re;
                  opWe_d  = we;
                  addr_d  = addr;
                  data_d  = dIn;
                  cnt_d   = WAIT_LOAD;
                  rdy_d   = 1'b0;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               accDo   = 1'b1;
               accRe   = opRe_q;
               accWe   = opWe_q;
               accAddr = addr_q;
               accData = data_q;
               rdy_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accIdx         = accAddr[DEPTH_LOG2-1:0];
   assign unusedAddrBits = ^accAddr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         opRe_q  <= 1'b0;
         opWe_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= 8'h00;
         rdy_q   <= 1'b1;
         dOut_q  <= 8'h00;
         count_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opRe_q  <= opRe_d;
         opWe_q  <= opWe_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         if (accDo) begin
            count_q <= count_q + 16'd1;
         end
         // A write wins over a simultaneous read, so dOut only moves on pure reads.
         if (accDo && accRe && !accWe) begin
            dOut_q <= mem_q[accIdx];
         end
      end
   end

   // Storage has no reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (accDo && accWe) begin
         mem_q[accIdx] <= accData;
      end
   end

`ifdef BUS_WAIT_MEMORY_TRAP_EN
   logic trap_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trap_q <= 1'b0;
      end else if (accDo && accRe && !accWe && (accAddr[15:0] == TRAP_ADDR)) begin
         trap_q <= 1'b1;
      end
   end

   assign trap = trap_q;
`else
   assign trap = 1'b0;
`endif

   assign dOut         = dOut_q;
   assign rdy          = rdy_q;
   assign access_count = count_q;

endmodule

// File: tb/tb_bus_wait_memory.sv
// Self-checking bench for bus_wait_memory: three instances with 0, 3 and 5 wait
// states are checked every cycle against a transaction-level memory model.
module tb_bus_wait_memory;

   localparam int AW = 21;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]    rst;
   logic [2:0]    re;
   logic [2:0]    we;
   logic [AW-1:0] addr [3];
   logic [7:0]    dIn  [3];
   logic [7:0]    dOut [3];
   logic [2:0]    rdy;
   logic [2:0]    trap;
   logic [15:0]   cnt  [3];

   bus_wait_memory #(.ADDR_W(AW), .DEPTH_LOG2(16), .WAIT_CYCLES(0), .TRAP_ADDR(16'hBEEF)) u0 (
      .clk(clk), .reset(rst[0]), .re(re[0]), .we(we[0]), .addr(addr[0]), .dIn(dIn[0]),
      .dOut(dOut[0]), .rdy(rdy[0]), .trap(trap[0]), .access_count(cnt[0]));

   bus_wait_memory #(.ADDR_W(AW), .DEPTH_LOG2(16), .WAIT_CYCLES(3), .TRAP_ADDR(16'hBEEF)) u1 (
      .clk(clk), .reset(rst[1]), .re(re[1]), .we(we[1]), .addr(addr[1]), .dIn(dIn[1]),
      .dOut(dOut[1]), .rdy(rdy[1]), .trap(trap[1]), .access_count(cnt[1]));

   bus_wait_memory #(.ADDR_W(AW), .DEPTH_LOG2(16), .WAIT_CYCLES(5), .TRAP_ADDR(16'hBEEF)) u2 (
      .clk(clk), .reset(rst[2]), .re(re[2]), .we(we[2]), .addr(addr[2]), .dIn(dIn[2]),
      .dOut(dOut[2]), .rdy(rdy[2]), .trap(trap[2]), .access_count(cnt[2]));

   int          waitCycles [3] = '{0, 3, 5};
   logic [7:0]  mem  [3][65536];
   logic [7:0]  expD [3];
   logic        expR [3];
   logic [15:0] expC [3];
   logic        expT [3];
   int          checks   = 0;
   int          failures = 0;
   int          lowCnt1  = 0;

   task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of one completed access: memory array plus the visible registers.
   function automatic void complete(int k, logic r, logic w, logic [AW-1:0] a, logic [7:0] d);
      if (w) begin
         mem[k][a[15:0]] = d;
      end else if (r) begin
         expD[k] = mem[k][a[15:0]];
`ifdef BUS_WAIT_MEMORY_TRAP_EN
         if (a[15:0] == 16'hBEEF) expT[k] = 1'b1;
`endif
      end
      expC[k] = expC[k] + 16'd1;
   endfunction

   function automatic void modelReset(int k);
      expD[k] = 8'h00;
      expR[k] = 1'b1;
      expC[k] = 16'h0000;
      expT[k] = 1'b0;
   endfunction

   task automatic applyStimulus(int k, logic r, logic w, logic [AW-1:0] a, logic [7:0] d, bit hold);
      @(negedge clk);
      re[k] = r; we[k] = w; addr[k] = a; dIn[k] = d;
      @(posedge clk);
      if (waitCycles[k] == 0) begin
         complete(k, r, w, a, d);
      end else begin
         expR[k] = 1'b0;
         if (!hold) begin
            @(negedge clk);
            re[k] = 1'b0; we[k] = 1'b0; addr[k] = ~a; dIn[k] = ~d;
         end
         repeat (waitCycles[k]) @(posedge clk);
         complete(k, r, w, a, d);
         expR[k] = 1'b1;
      end
   endtask

   task automatic idle(int k);
      @(negedge clk);
      re[k] = 1'b0; we[k] = 1'b0;
   endtask

   task automatic pulseReset(int k);
      @(negedge clk);
      rst[k] = 1'b1;
      modelReset(k);
      @(negedge clk);
      rst[k] = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("u%0d.dOut", k), 16'(dOut[k]), 16'(expD[k]));
            checkOutput($sformatf("u%0d.rdy", k), 16'(rdy[k]), 16'(expR[k]));
            checkOutput($sformatf("u%0d.count", k), cnt[k], expC[k]);
            checkOutput($sformatf("u%0d.trap", k), 16'(trap[k]), 16'(expT[k]));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rdy[1]) lowCnt1++;
      end
   end

   initial begin
      rst = 3'b111;
      re  = 3'b000;
      we  = 3'b000;
      for (int k = 0; k < 3; k++) begin
         addr[k] = '0;
         dIn[k]  = 8'h00;
         modelReset(k);
      end
      #2;
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("reset.u%0d.dOut", k), 16'(dOut[k]), 16'h0000);
         checkOutput($sformatf("reset.u%0d.rdy", k), 16'(rdy[k]), 16'h0001);
         checkOutput($sformatf("reset.u%0d.count", k), cnt[k], 16'h0000);
      end
      @(negedge clk);
      rst = 3'b000;

      // Zero wait states: basic write/read, aliasing, read+write collision, trap.
      applyStimulus(0, 1'b0, 1'b1, 21'h00100, 8'h5A, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 21'h00100, 8'h00, 1'b0);
      #1;
      checkOutput("w0.readBack", 16'(dOut[0]), 16'h005A);
      checkOutput("w0.count2", cnt[0], 16'd2);
      applyStimulus(0, 1'b0, 1'b1, 21'h10010, 8'hC3, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 21'h00010, 8'h00, 1'b0);
      #1;
      checkOutput("alias", 16'(dOut[0]), 16'h00C3);
      applyStimulus(0, 1'b1, 1'b0, 21'h00100, 8'h00, 1'b0);
      applyStimulus(0, 1'b1, 1'b1, 21'h00020, 8'h77, 1'b0);
      #1;
      checkOutput("rwHold", 16'(dOut[0]), 16'h005A);
      applyStimulus(0, 1'b1, 1'b0, 21'h00020, 8'h00, 1'b0);
      #1;
      checkOutput("rwWritten", 16'(dOut[0]), 16'h0077);
      applyStimulus(0, 1'b0, 1'b1, 21'h0BEEF, 8'h12, 1'b0);
      #1;
      checkOutput("trapWrite", 16'(trap[0]), 16'h0000);
      applyStimulus(0, 1'b1, 1'b0, 21'h0BEEF, 8'h00, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 21'h00100, 8'h00, 1'b0);
      #1;
`ifdef BUS_WAIT_MEMORY_TRAP_EN
      checkOutput("trapSticky", 16'(trap[0]), 16'h0001);
`else
      checkOutput("trapOff", 16'(trap[0]), 16'h0000);
`endif
      idle(0);

      // Three wait states: write with changing bus, reset keeps storage, held read.
      applyStimulus(1, 1'b0, 1'b1, 21'h00040, 8'h9C, 1'b0);
      pulseReset(1);
      lowCnt1 = 0;
      applyStimulus(1, 1'b1, 1'b0, 21'h00040, 8'h00, 1'b1);
      #1;
      checkOutput("w3.data", 16'(dOut[1]), 16'h009C);
      checkOutput("w3.count1", cnt[1], 16'd1);
      idle(1);
      checkOutput("w3.rdyLowCycles", 16'(lowCnt1), 16'd3);

      // Five wait states: reset in the second wait cycle abandons the write.
      applyStimulus(2, 1'b0, 1'b1, 21'h00030, 8'h11, 1'b0);
      @(negedge clk);
      we[2] = 1'b1; re[2] = 1'b0; addr[2] = 21'h00030; dIn[2] = 8'hAA;
      @(posedge clk);
      expR[2] = 1'b0;
      @(negedge clk);
      we[2] = 1'b0;
      @(posedge clk);
      #3;
      rst[2] = 1'b1;
      modelReset(2);
      #1;
      checkOutput("w5.resetRdy", 16'(rdy[2]), 16'h0001);
      checkOutput("w5.resetCount", cnt[2], 16'h0000);
      @(negedge clk);
      rst[2] = 1'b0;
      applyStimulus(2, 1'b1, 1'b0, 21'h00030, 8'h00, 1'b0);
      #1;
      checkOutput("w5.oldData", 16'(dOut[2]), 16'h0011);
      checkOutput("w5.count1", cnt[2], 16'd1);

      // Back-to-back reads on the zero-wait instance carry the counter across its wrap.
      @(negedge clk);
      re[0] = 1'b1; we[0] = 1'b0; addr[0] = 21'h00100;
      for (int i = 0; i < 65529; i++) begin
         @(posedge clk);
         complete(0, 1'b1, 1'b0, 21'h00100, 8'h00);
      end
      idle(0);
      checkOutput("countWrap", cnt[0], 16'd3);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_wait_memory.md
BUS_WAIT_MEMORY -- requirements
Module: bus_wait_memory

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 21, width of the bus address; DEPTH_LOG2, default 16, log2 of the storage depth in bytes; WAIT_CYCLES, default 0, wait states per access (range 0..15); TRAP_ADDR, default 16'hBEEF, low 16 bits of the completion-trap address.
REQ-002 clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 re  input  1  read request.
REQ-005 we  input  1  write request.
REQ-006 addr  input  ADDR_W  byte address.
REQ-007 dIn  input  8  write data.
REQ-008 dOut  output  8  registered read data.
REQ-009 rdy  output  1  registered ready; low means the bus master SHALL hold re/we/addr/dIn.
REQ-010 trap  output  1  sticky flag: a read completed at TRAP_ADDR.
REQ-011 access_count  output  16  count of completed accesses.

Function
REQ-012 Storage SHALL be 2**DEPTH_LOG2 bytes, indexed by addr[DEPTH_LOG2-1:0]; higher address bits SHALL alias.
REQ-013 FSM states SHALL be IDLE and WAIT.
REQ-014 IDLE with WAIT_CYCLES==0: on an edge with re|we high, the access SHALL complete on that edge; read data SHALL appear on dOut after that edge (1-cycle latency); rdy SHALL stay 1.
REQ-015 IDLE with WAIT_CYCLES>0: on an edge with re|we high, the block SHALL latch op/addr/dIn, load counter=WAIT_CYCLES-1, drive rdy=0 and go to WAIT.
REQ-016 WAIT: on each edge with counter!=0, counter SHALL decrement; on the edge with counter==0, the latched access SHALL complete, rdy SHALL return to 1 and state SHALL return to IDLE; rdy is therefore low for exactly WAIT_CYCLES cycles.
REQ-017 Inputs SHALL be ignored in WAIT; the latched values SHALL be used.
REQ-018 re and we high together: the write SHALL be performed and dOut SHALL hold its previous value.
REQ-019 A write SHALL not change dOut.
REQ-020 Back-to-back accesses: a new request in IDLE on the edge after completion SHALL be accepted with no bubble.
REQ-021 access_count SHALL increment by 1 on each completed read or write and SHALL wrap from 16'hFFFF to 0.
REQ-022 trap SHALL set on completion of a read with addr[15:0]==TRAP_ADDR and SHALL remain set until reset; writes to TRAP_ADDR SHALL not set it.

Reset
REQ-023 Reset SHALL force state IDLE, counter 0, rdy 1, dOut 8'h00, trap 0 and access_count 0 immediately, independent of clk.
REQ-024 Reset during WAIT SHALL abandon the latched access: no write is performed and no count is taken.
REQ-025 Storage contents SHALL not be altered by reset.

Configuration
REQ-026 Macro BUS_WAIT_MEMORY_TRAP_EN defined: trap logic per REQ-022 SHALL be present.
REQ-027 Macro BUS_WAIT_MEMORY_TRAP_EN undefined: trap SHALL be tied to 0, no trap compare logic SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-028 WAIT_CYCLES=0: write 8'h5A to addr 21'h00100, then read 21'h00100 -> dOut=8'h5A one edge after the read edge, rdy constantly 1, access_count=2.
REQ-029 WAIT_CYCLES=3: read request held -> rdy low for exactly 3 cycles, data valid and rdy=1 after the 4th edge, access_count=1.
REQ-030 Alias: DEPTH_LOG2=16, write 8'hC3 to 21'h10010, read 21'h00010 -> dOut=8'hC3.
REQ-031 re and we both high, dIn=8'h77, addr 21'h00020, prior dOut=8'h5A -> dOut stays 8'h5A; a subsequent read of 21'h00020 returns 8'h77.
REQ-032 With BUS_WAIT_MEMORY_TRAP_EN defined: a write to 21'h0BEEF leaves trap=0; a read of 21'h0BEEF sets trap=1, which stays 1 until reset. With the macro undefined, trap=0 throughout.
REQ-033 WAIT_CYCLES=5: assert reset during the 2nd wait cycle of a write of 8'hAA to 21'h00030 -> rdy=1 and access_count=0 immediately; a subsequent read of 21'h00030 returns the old contents.
